// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM state encoding and
// the width of the optional stall counters.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous active-high reset. It sticks at
// all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage,
// and derives the pipeline stall controls. Optional stall counters: MEM_ARB_PERF_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [DATA_W-1:0] ex_mem_wdata,
    output logic [DATA_W-1:0] mem_stage_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              pc_load,
    output logic              IF_ID_load,
    output logic              ID_EX_bubble,
    output logic              pipe_hold,
`ifdef MEM_ARB_PERF_EN
    output logic [CNT_W-1:0]  fetch_stall_cnt,
    output logic [CNT_W-1:0]  data_stall_cnt,
`endif
    output arb_state_t        fsm_state,
    output logic              data_done
);

    // Memory handshake: mem_req rises with a stable mem_we/mem_addr/mem_wdata and
    // holds them until the one-cycle mem_ack, which also carries mem_rdata.
    logic dreq;

    assign dreq         = (ex_mem_read | ex_mem_write) & ~data_done;
    assign pipe_hold    = ~rst & dreq;
    assign pc_load      = ~rst & if_valid & ~dreq;
    assign IF_ID_load   = pc_load;
    assign ID_EX_bubble = rst | (~if_valid & ~dreq);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_state       <= IDLE;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            if_rdata        <= '0;
            if_valid        <= 1'b0;
            mem_stage_rdata <= '0;
            data_done       <= 1'b0;
        end else begin
            if (pc_load) begin
                if_valid <= 1'b0;
            end
            // data_done masks the finished access until the pipe releases it.
            if (fsm_state == DATA && mem_ack) begin
                data_done <= 1'b1;
            end else if (!pipe_hold) begin
                data_done <= 1'b0;
            end
            case (fsm_state)
                IDLE: begin
                    if (dreq) begin
                        fsm_state <= DATA;
                        mem_req   <= 1'b1;
                        mem_we    <= ex_mem_write;
                        mem_addr  <= ex_mem_addr;
                        mem_wdata <= ex_mem_wdata;
                    end else if (!if_valid) begin
                        fsm_state <= FETCH;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        fsm_state <= IDLE;
                        mem_req   <= 1'b0;
                        if_rdata  <= mem_rdata;
                        if_valid  <= 1'b1;
                    end
                end
                DATA: begin
                    if (mem_ack) begin
                        fsm_state <= IDLE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        if (!mem_we) begin
                            mem_stage_rdata <= mem_rdata;
                        end
                    end
                end
                default: fsm_state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    sat_counter #(.WIDTH(CNT_W)) u_fetch_stall (
        .clk   (clk),
        .rst   (rst),
        .inc   (ID_EX_bubble),
        .count (fetch_stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_data_stall (
        .clk   (clk),
        .rst   (rst),
        .inc   (pipe_hold),
        .count (data_stall_cnt)
    );
`endif

`ifndef SYNTHESIS
    // A simultaneous read and write is executed as a write but is a core bug.
    rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(ex_mem_read && ex_mem_write));
`endif

endmodule
